uart_tx_arbiter: RTL and testbench

Packet-level round-robin arbiter and sequencer in front of the shared `async_transmitter`. Up to `NUM_REQ` byte-stream sources present bytes over a valid/ready handshake. The block grants the single UART to one source for a whole packet, terminated by a `last` flag. It then drives the transmitter's start/data/busy handshake byte by byte, so sources never touch the UART directly.

---
 rtl/uart_tx_arb_pkg.sv | 24 ++
 rtl/uart_tx_arbiter_rr_arbiter.sv | 38 +++
 rtl/uart_tx_arbiter.sv | 160 ++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_arb_pkg.sv
// Shared definitions for the UART transmit arbiter: sequencer states and
// the requester count limit.
package uart_tx_arb_pkg;

    localparam int MAX_REQ = 8;

    // Encodings kept as plain constants so older code can compare raw state bits.
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_ARB   = 3'd1;
    localparam logic [2:0] ST_FETCH = 3'd2;
    localparam logic [2:0] ST_START = 3'd3;
    localparam logic [2:0] ST_ACK   = 3'd4;
    localparam logic [2:0] ST_DRAIN = 3'd5;

    typedef enum logic [2:0] {
        IDLE  = ST_IDLE,
        ARB   = ST_ARB,
        FETCH = ST_FETCH,
        START = ST_START,
        ACK   = ST_ACK,
        DRAIN = ST_DRAIN
    } arbStateT;

endpackage

// File: rtl/uart_tx_arbiter_rr_arbiter.sv
// Combinational round-robin picker: the lowest requesting index at or after
// ptr wins, wrapping past NUM_REQ-1 back to 0.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    localparam int IDX_W  = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grantIdx,
    output logic               anyReq
);

    logic [IDX_W:0]   sum;
    logic [IDX_W-1:0] cand;

    // Walk the requesters starting at ptr and keep the first one found.
    always_comb begin
        grant    = '0;
        grantIdx = '0;
        anyReq   = 1'b0;
        sum      = '0;
        cand     = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            sum = {1'b0, ptr} + (IDX_W + 1)'(i);
            if (sum >= (IDX_W + 1)'(NUM_REQ)) begin
                sum = sum - (IDX_W + 1)'(NUM_REQ);
            end
            cand = sum[IDX_W-1:0];
            if (!anyReq && req[cand]) begin
                anyReq      = 1'b1;
                grant[cand] = 1'b1;
                grantIdx    = cand;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-level round-robin arbiter in front of a single async_transmitter.
// One source owns the UART from its first byte until its last-flagged byte
// (or until it starves the lock for LOCK_TIMEOUT cycles); bytes are handed to
// the transmitter one at a time over its start/busy handshake.
//
// state | meaning
// IDLE  | no owner; wait for any valid while the transmitter is idle
// ARB   | register the round-robin winner and take the lock
// FETCH | ready to the owner; latch its byte on transfer
// START | one-cycle start pulse to the transmitter
// ACK   | wait for the transmitter to raise busy
// DRAIN | wait for busy to drop; next byte or release the lock
module uart_tx_arbiter
    import uart_tx_arb_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int LOCK_TIMEOUT = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [8*NUM_REQ-1:0]       req_data,
    input  logic [NUM_REQ-1:0]         req_last,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic                       tx_start,
    output logic [7:0]                 tx_data,
    input  logic                       tx_busy,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       locked,
    output logic                       timeout_err
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT + 1) : 1;

    if (NUM_REQ < 2 || NUM_REQ > MAX_REQ) begin : gBadNumReq
        $error("uart_tx_arbiter: NUM_REQ out of range");
    end

    arbStateT            state;
    logic [IDX_W-1:0]    ptr;
    logic [IDX_W-1:0]    nextPtr;
    logic [NUM_REQ-1:0]  ownerMask;
    logic [CNT_W-1:0]    idleCnt;
    logic                lastR;

    logic [NUM_REQ-1:0]  arbGrant;
    logic [IDX_W-1:0]    arbIdx;
    logic                arbAny;

    logic                ownerValid;
    logic                ownerLast;
    logic [7:0]          ownerData;
    logic                xfer;
    logic                timeoutHit;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) uRrArbiter (
        .req      (req_valid),
        .ptr      (ptr),
        .grant    (arbGrant),
        .grantIdx (arbIdx),
        .anyReq   (arbAny)
    );

    // Owner-side view of the request bus and the handshake decode.
    always_comb begin
        ownerValid = req_valid[grant_id];
        ownerLast  = req_last[grant_id];
        ownerData  = req_data[{grant_id, 3'b000} +: 8];
        xfer       = (state == FETCH) && ownerValid;
        req_ready  = (state == FETCH) ? ownerMask : '0;
        tx_start   = (state == START);
        nextPtr    = (grant_id == IDX_W'(NUM_REQ - 1)) ? '0 : grant_id + IDX_W'(1);
        timeoutHit = 1'b0;
        if (LOCK_TIMEOUT > 0) begin
            timeoutHit = (state == FETCH) && !ownerValid &&
                         (idleCnt == CNT_W'(LOCK_TIMEOUT - 1));
        end
    end

    // Sequencer: arbitration, byte latch, transmitter handshake and lock release.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            ptr         <= '0;
            grant_id    <= '0;
            ownerMask   <= '0;
            locked      <= 1'b0;
            tx_data     <= '0;
            lastR       <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            timeout_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (arbAny && !tx_busy) begin
                        state <= ARB;
                    end
                end
                ARB: begin
                    // A requester may have withdrawn since IDLE; nothing to grant then.
                    if (arbAny) begin
                        grant_id  <= arbIdx;
                        ownerMask <= arbGrant;
                        locked    <= 1'b1;
                        state     <= FETCH;
                    end else begin
                        state <= IDLE;
                    end
                end
                FETCH: begin
                    if (xfer) begin
                        tx_data <= ownerData;
                        lastR   <= ownerLast;
                        state   <= START;
                    end else if (timeoutHit) begin
                        timeout_err <= 1'b1;
                        locked      <= 1'b0;
                        ptr         <= nextPtr;
                        state       <= IDLE;
                    end
                end
                START: begin
                    state <= ACK;
                end
                ACK: begin
                    if (tx_busy) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (!tx_busy) begin
                        if (lastR) begin
                            locked <= 1'b0;
                            ptr    <= nextPtr;
                            state  <= IDLE;
                        end else begin
                            state <= FETCH;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Starvation counter: counts FETCH cycles with the owner's valid low.
    always_ff @(posedge clk) begin
        if (rst) begin
            idleCnt <= '0;
        end else if (state != FETCH || xfer || timeoutHit) begin
            idleCnt <= '0;
        end else if (LOCK_TIMEOUT > 0) begin
            idleCnt <= idleCnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: random packet sources, a behavioural transmitter,
// and a packet-level round-robin model that predicts the byte stream on TxD.
module tb_uart_tx_arbiter;

    localparam int N  = 4;
    localparam int TO = 16;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [N-1:0]     req_valid;
    logic [8*N-1:0]   req_data;
    logic [N-1:0]     req_last;
    logic [N-1:0]     req_ready;
    logic             tx_start;
    logic [7:0]       tx_data;
    logic             tx_busy;
    logic [1:0]       grant_id;
    logic             locked;
    logic             timeout_err;

    always #5 clk = ~clk;

    uart_tx_arbiter #(.NUM_REQ(N), .LOCK_TIMEOUT(TO)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_last    (req_last),
        .req_ready   (req_ready),
        .tx_start    (tx_start),
        .tx_data     (tx_data),
        .tx_busy     (tx_busy),
        .grant_id    (grant_id),
        .locked      (locked),
        .timeout_err (timeout_err)
    );

    int vectors     = 0;
    int miscompares = 0;

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Source byte queues ({last, data}), model packet lists, expected TxD stream ({src, data}).
    logic [8:0] srcQ[N][$];
    int         pendLen[N][$];
    logic [7:0] pendByte[N][$];
    int         curLen[N];
    logic [9:0] expQ[$];
    int         modelPtr = 0;

    bit         midPkt[N];
    int         stallCnt[N];
    bit         randTiming   = 1'b0;
    bit         pendingStart = 1'b0;
    int         riseLeft     = 0;
    int         frameLeft    = 0;
    logic [7:0] capData      = 8'h00;
    int         starveRun    = 0;
    int         toCount      = 0;

    task automatic closePkt(input int s);
        pendLen[s].push_back(curLen[s]);
        curLen[s] = 0;
    endtask

    task automatic addByte(input int s, input logic [7:0] b, input logic isLast);
        srcQ[s].push_back({isLast, b});
        pendByte[s].push_back(b);
        curLen[s]++;
        if (isLast) closePkt(s);
    endtask

    task automatic addRandPkt(input int s, input int len);
        for (int k = 0; k < len; k++) addByte(s, 8'($urandom), (k == len - 1));
    endtask

    // Packet-level round robin: whole packets, lowest pending source at/after the pointer.
    task automatic runModel();
        bit any;
        int s;
        do begin
            any = 1'b0;
            for (int k = 0; k < N; k++) begin
                s = (modelPtr + k) % N;
                if (pendLen[s].size() > 0) begin
                    int len;
                    len = pendLen[s].pop_front();
                    for (int j = 0; j < len; j++) expQ.push_back({2'(s), pendByte[s].pop_front()});
                    modelPtr = (s + 1) % N;
                    any = 1'b1;
                    break;
                end
            end
        end while (any);
    endtask

    task automatic clearAll();
        for (int s = 0; s < N; s++) begin
            srcQ[s].delete();
            pendLen[s].delete();
            pendByte[s].delete();
            curLen[s]   = 0;
            midPkt[s]   = 1'b0;
            stallCnt[s] = 0;
        end
        expQ.delete();
        modelPtr = 0;
    endtask

    task automatic doReset();
        @(posedge clk); #1;
        rst = 1'b1;
        clearAll();
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic waitDone(input int budget);
        int left;
        for (int n = 0; n < budget; n++) begin
            @(negedge clk);
            left = 0;
            for (int s = 0; s < N; s++) left += srcQ[s].size();
            if (expQ.size() == 0 && left == 0 && !tx_busy && !pendingStart && !locked) break;
        end
        checkVal("drainExp", 32'(expQ.size()), 0);
        checkVal("drainLocked", 32'(locked), 0);
        repeat (2) @(negedge clk);
    endtask

    task automatic checkResetOutputs(input string tag);
        checkVal({tag, "_ready"},   32'(req_ready), 0);
        checkVal({tag, "_start"},   32'(tx_start), 0);
        checkVal({tag, "_data"},    32'(tx_data), 0);
        checkVal({tag, "_grant"},   32'(grant_id), 0);
        checkVal({tag, "_locked"},  32'(locked), 0);
        checkVal({tag, "_timeout"}, 32'(timeout_err), 0);
    endtask

    // Sources, transmitter and TxD monitor, all in one cycle loop.
    initial begin
        logic [N-1:0] xfer;
        logic [9:0]   e;
        logic [8:0]   b;
        bit           stall;
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        tx_busy   = 1'b0;
        forever begin
            @(negedge clk);
            xfer = req_valid & req_ready;
            if (tx_start) begin
                checkVal("startNotBusy", 32'(tx_busy), 0);
                checkVal("startExpected", 32'(expQ.size() > 0), 1);
                if (expQ.size() > 0) begin
                    e = expQ.pop_front();
                    checkVal("txByte", 32'(tx_data), 32'(e[7:0]));
                    checkVal("txOwner", 32'(grant_id), 32'(e[9:8]));
                end
                pendingStart = 1'b1;
                capData      = tx_data;
                riseLeft     = randTiming ? int'($urandom_range(3, 1)) : 1;
            end else if (pendingStart) begin
                checkVal("dataHold", 32'(tx_data), 32'(capData));
            end
            if (req_ready != '0) begin
                checkVal("readyOwner", 32'(req_ready), 32'(4'b0001 << grant_id));
                checkVal("readyLocked", 32'(locked), 1);
            end
            if (timeout_err) begin
                toCount++;
                checkVal("timeoutDelay", 32'(starveRun), TO);
                checkVal("timeoutUnlock", 32'(locked), 0);
                starveRun = 0;
                for (int s = 0; s < N; s++) midPkt[s] = 1'b0;
            end else if (req_ready != '0 && xfer == '0) begin
                starveRun++;
            end else begin
                starveRun = 0;
            end

            @(posedge clk); #1;
            for (int s = 0; s < N; s++) begin
                if (xfer[s] && srcQ[s].size() > 0) begin
                    b = srcQ[s].pop_front();
                    midPkt[s] = !b[8];
                end
            end
            if (pendingStart) begin
                riseLeft--;
                if (riseLeft <= 0) begin
                    pendingStart = 1'b0;
                    tx_busy      = 1'b1;
                    frameLeft    = int'($urandom_range(8, 4)) +
                                   (randTiming ? int'($urandom_range(10, 0)) : 0);
                end
            end else if (tx_busy) begin
                frameLeft--;
                if (frameLeft <= 0) tx_busy = 1'b0;
            end
            for (int s = 0; s < N; s++) begin
                if (srcQ[s].size() > 0) begin
                    stall = midPkt[s] && (stallCnt[s] < 5) && ($urandom_range(3, 0) == 0);
                    stallCnt[s] = stall ? stallCnt[s] + 1 : 0;
                    req_valid[s] = !stall;
                    b = srcQ[s][0];
                    req_data[8*s +: 8] = stall ? 8'($urandom) : b[7:0];
                    req_last[s]        = stall ? 1'($urandom) : b[8];
                end else begin
                    req_valid[s]       = 1'b0;
                    req_data[8*s +: 8] = 8'($urandom);
                    req_last[s]        = 1'($urandom);
                end
            end
        end
    end

    // Scenario sequence.
    initial begin
        int startAt;
        int npk;
        for (int s = 0; s < N; s++) begin
            curLen[s] = 0; midPkt[s] = 1'b0; stallCnt[s] = 0;
        end
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checkResetOutputs("reset");

        // Single source on requester 2, with first-byte latency measurement.
        @(posedge clk); #2;
        addByte(2, 8'h55, 1'b0);
        addByte(2, 8'hA3, 1'b1);
        runModel();
        @(posedge clk);
        @(negedge clk);
        startAt = -1;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (k == 2) checkVal("firstReady", 32'(req_ready), 32'(4'b0100));
            if (tx_start && startAt < 0) startAt = k;
        end
        checkVal("firstStartLat", 32'(startAt), 3);
        waitDone(500);

        // Pointer now sits at 3: requesters 0 and 3 together must go 3 then 0.
        @(posedge clk); #2;
        addRandPkt(0, 1);
        addRandPkt(3, 1);
        runModel();
        waitDone(500);

        // Contention from reset: four 2-byte packets.
        doReset();
        @(posedge clk); #2;
        for (int s = 0; s < N; s++) addRandPkt(s, 2);
        runModel();
        waitDone(1000);

        // Fairness: requester 0 keeps re-requesting while 1 and 3 wait.
        @(posedge clk); #2;
        addRandPkt(0, 1);
        addRandPkt(0, 1);
        addRandPkt(1, 1);
        addRandPkt(3, 1);
        runModel();
        waitDone(1000);

        // Random packets with stretched busy rise and frame length.
        randTiming = 1'b1;
        repeat (6) begin
            @(posedge clk); #2;
            for (int s = 0; s < N; s++) begin
                if ($urandom_range(1, 0) == 1 || s == 0) begin
                    npk = int'($urandom_range(3, 1));
                    for (int p = 0; p < npk; p++) addRandPkt(s, int'($urandom_range(4, 1)));
                end
            end
            runModel();
            waitDone(5000);
        end
        randTiming = 1'b0;
        checkVal("noSpuriousTimeout", 32'(toCount), 0);

        // Timeout: requester 1 sends one non-last byte and goes silent.
        @(posedge clk); #2;
        addByte(1, 8'h11, 1'b0);
        closePkt(1);
        addByte(3, 8'h33, 1'b1);
        runModel();
        waitDone(1000);
        checkVal("timeoutCount", 32'(toCount), 1);

        // Reset during DRAIN; pointer is 3 beforehand.
        @(posedge clk); #2;
        addByte(2, 8'h5A, 1'b1);
        runModel();
        waitDone(500);
        @(posedge clk); #2;
        addByte(2, 8'h61, 1'b0);
        addByte(2, 8'h62, 1'b0);
        addByte(2, 8'h63, 1'b1);
        runModel();
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (tx_busy && locked) break;
        end
        checkVal("busyBeforeReset", 32'(tx_busy && locked), 1);
        @(posedge clk); #1;
        rst = 1'b1;
        clearAll();
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        checkResetOutputs("midReset");
        addRandPkt(1, 1);
        addRandPkt(3, 1);
        runModel();
        waitDone(1000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
